id_ex_elastic_reg: RTL and testbench
====================================

// Module: id_ex_elastic_reg
// PURPOSE
//  Parametrised, flow-controlled ID->EX pipeline register with a two-entry skid buffer.
//  Replaces the fixed-field, always-advancing stage register.
//  Adds valid/ready back-pressure (EX stall without losing an issued instruction) and
//  bubble insertion with zeroed control bits.
//  Carries two opaque buses (control, data) so field layouts can change without RTL edits.
// PARAMETERS
//  CTRL_W      10   control bits (MEM_R_EN, MEM_W_EN, WB_EN, Imm, B, S, EX_CMD); zeroed in bubbles
//  DATA_W      140  payload bits (status, dest, imm24, shifter op, PC, Val_Rn, Val_Rm)
//  CLEAR_DATA  0    1: out_data also forced to 0 when out_valid=0; 0: out_data holds last value
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  flush      in   1       synchronous kill of all held and incoming entries (branch taken)
//  in_valid   in   1       ID presents an instruction
//  in_ready   out  1       stage can accept; registered (no comb path from out_ready)
//  in_ctrl    in   CTRL_W  control bits from ID
//  in_data    in   DATA_W  payload from ID
//  out_valid  out  1       entry presented to EX
//  out_ready  in   1       EX consumes the entry this cycle
//  out_ctrl   out  CTRL_W  control bits to EX; all-zero whenever out_valid=0
//  out_data   out  DATA_W  payload to EX
//  occupancy  out  2       entries held: 0, 1 or 2
// BEHAVIOUR
//  Storage: main reg (drives outputs) + skid reg. States: EMPTY(0), ONE(main), FULL(main+skid).
//  Transfer rules: accept = in_valid & in_ready; consume = out_valid & out_ready.
//  Reset (async): both entries invalid; out_valid=0, in_ready=1, occupancy=0; out_ctrl=0, out_data=0.
//  Latency: 1 cycle. Entry accepted at edge N appears on out_* after edge N.
//  Throughput: 1/cycle when out_ready=1 continuously.
//  EMPTY:
//   - accept -> ONE (main<=in).
//  ONE:
//   - accept & consume -> ONE (main<=in).
//   - accept & !consume -> FULL (skid<=in).
//   - !accept & consume -> EMPTY.
//  FULL:
//   - in_ready=0, so no accept is possible.
//   - consume -> ONE (main<=skid).
//   - !consume -> hold, outputs stable.
//  in_ready = (state != FULL), driven from a flop.
//  Ordering is strictly FIFO. No entry is duplicated or dropped except by flush.
//  flush (highest priority after rst):
//   - at the next edge both entries are invalidated; state->EMPTY.
//   - the same-cycle in_valid is discarded, even if in_ready=1.
//   - the same-cycle consume still counts for EX.
//   - out_ctrl=0 from the next cycle.
//  Bubble: out_valid=0 forces out_ctrl=0, combinationally masked from the stored value.
//   - out_data holds its last value, or is 0 if CLEAR_DATA=1.
//  occupancy = registered count, consistent with state.
//  in_valid=0 with in_ready=1 is legal. in_* values are ignored when not accepted.
//  Simultaneous rst and flush: rst wins (async).
// TESTING
//  1. Reset mid-stream: rst pulse while FULL -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0 with no clock edge.
//  2. Streaming: out_ready=1; in_data = 1,2,3,4 on consecutive cycles
//     -> out_data 1,2,3,4 one cycle later, no gaps, occupancy stays 1.
//  3. Back-pressure: hold out_ready=0 and send A,B
//     -> occupancy=2, in_ready=0, C is held off.
//     Release out_ready -> A, B, C emerge in order, none lost.
//  4. Flush: flush while FULL with in_valid=1 (D)
//     -> next cycle out_valid=0, out_ctrl=0, occupancy=0, D never appears.
//  5. Bubble masking: in_ctrl=10'h3FF accepted then consumed, no new input
//     -> out_ctrl=0 once out_valid=0.
//     With CLEAR_DATA=0 out_data holds; with CLEAR_DATA=1 out_data=0.
//  6. Random valid/ready with rare flush, 10k cycles, against a scoreboard queue
//     -> order preserved, occupancy never exceeds 2.

Source files
------------

// File: rtl/id_ex_elastic_reg.sv
// ID->EX pipeline register with valid/ready flow control and a two-entry skid buffer.
// The control and data buses are opaque, and control is masked to zero whenever no entry is presented.
module id_ex_elastic_reg #(
  parameter int unsigned CTRL_W     = 10,
  parameter int unsigned DATA_W     = 140,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic [1:0]          occ_q, occ_d;
  logic                accept_s;
  logic                consume_s;

  assign accept_s  = in_valid & in_ready_q;
  assign consume_s = out_valid_q & out_ready;

  // Next-state and storage steering; flush overrides every transfer except the EX-side consume.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && consume_s) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            state_d     = ST_ONE;
          end else if (accept_s) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            state_d     = ST_FULL;
          end else if (consume_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so the skid entry is the only possible source for main
          if (consume_s) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ST_ONE;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake flags and count are decoded from the next state so they leave straight from flops.
  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    case (state_d)
      ST_EMPTY: occ_d = 2'd0;
      ST_ONE:   occ_d = 2'd1;
      ST_FULL:  occ_d = 2'd2;
      default:  occ_d = 2'd0;
    endcase
  end

  // State and storage registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      occ_q       <= occ_d;
    end
  end

  // Bubble masking: stale control must never reach EX, while stale data is optionally kept.
  always_comb begin
    if (out_valid_q) begin
      out_ctrl = main_ctrl_q;
    end else begin
      out_ctrl = {CTRL_W{1'b0}};
    end
    if (CLEAR_DATA && !out_valid_q) begin
      out_data = {DATA_W{1'b0}};
    end else begin
      out_data = main_data_q;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Self-checking bench: directed scenarios plus a negedge scoreboard monitor over two
// instances that differ only in CLEAR_DATA.
module tb_id_ex_elastic_reg;
  localparam int CW = 10;
  localparam int DW = 140;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t sb[$];
  logic [DW-1:0] last_main = '0;
  int sz;
  bit m_cons, m_acc;

  always #5 clk = ~clk;

  id_ex_elastic_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0));

  id_ex_elastic_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1));

  function automatic logic [DW-1:0] rand_data();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Scoreboard monitor: outputs are stable at the falling edge; the model then applies this cycle's transfers.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      last_main = '0;
    end else begin
      sz = sb.size();
      n_cmp++;
      if (occ0 !== 2'(sz) || occ1 !== 2'(sz)) begin
        n_bad++; $display("FAIL sb_occupancy: got %0d/%0d expected %0d", occ0, occ1, sz);
      end
      n_cmp++;
      if (out_valid0 !== (sz > 0) || out_valid1 !== (sz > 0) || in_ready0 !== (sz < 2) || in_ready1 !== (sz < 2)) begin
        n_bad++; $display("FAIL sb_flags: valid %b/%b ready %b/%b expected entries %0d", out_valid0, out_valid1, in_ready0, in_ready1, sz);
      end
      if (sz > 0) begin
        n_cmp++;
        if (out_ctrl0 !== sb[0].c || out_data0 !== sb[0].d || out_ctrl1 !== sb[0].c || out_data1 !== sb[0].d) begin
          n_bad++; $display("FAIL sb_entry: got ctrl %h data %h expected ctrl %h data %h", out_ctrl0, out_data0, sb[0].c, sb[0].d);
        end
        last_main = sb[0].d;
      end else begin
        n_cmp++;
        if (out_ctrl0 !== '0 || out_ctrl1 !== '0 || out_data0 !== last_main || out_data1 !== '0) begin
          n_bad++; $display("FAIL sb_bubble: ctrl %h/%h data0 %h data1 %h expected data0 %h", out_ctrl0, out_ctrl1, out_data0, out_data1, last_main);
        end
      end
      m_cons = (sz > 0) && out_ready;
      m_acc  = in_valid && (sz < 2);
      if (flush) begin
        sb.delete();
      end else begin
        if (m_cons) void'(sb.pop_front());
        if (m_acc) sb.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || occ0 !== 2'd0 || out_ctrl0 !== '0 || out_data0 !== '0 || out_data1 !== '0) begin
      n_bad++; $display("FAIL reset_state: valid %b ready %b occ %0d ctrl %h data %h", out_valid0, in_ready0, occ0, out_ctrl0, out_data0);
    end
    tick();
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick(); tick();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_ctrl = CW'(i); in_data = DW'(i);
      tick();
      n_cmp++;
      if (out_valid0 !== 1'b1 || out_data0 !== DW'(i) || occ0 !== 2'd1) begin
        n_bad++; $display("FAIL stream_%0d: valid %b data %0d occ %0d expected data %0d occ 1", i, out_valid0, out_data0, occ0, i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_bad++; $display("FAIL stream_end: valid %b expected 0", out_valid0);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 10'h0A1; in_data = DW'(32'hA);
    tick();
    in_ctrl = 10'h0B2; in_data = DW'(32'hB);
    tick();
    in_ctrl = 10'h0C3; in_data = DW'(32'hC);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (occ0 !== 2'd2 || in_ready0 !== 1'b0 || out_data0 !== DW'(32'hA)) begin
        n_bad++; $display("FAIL bp_full_%0d: occ %0d ready %b data %h expected 2/0/A", k, occ0, in_ready0, out_data0);
      end
      tick();
    end
    out_ready = 1'b1;
    n_cmp++;
    if (out_data0 !== DW'(32'hA)) begin
      n_bad++; $display("FAIL bp_first: data %h expected A", out_data0);
    end
    tick();
    n_cmp++;
    if (out_data0 !== DW'(32'hB) || occ0 !== 2'd1 || in_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL bp_second: data %h occ %0d ready %b expected B/1/1", out_data0, occ0, in_ready0);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_data0 !== DW'(32'hC) || out_ctrl0 !== 10'h0C3 || occ0 !== 2'd1) begin
      n_bad++; $display("FAIL bp_third: data %h ctrl %h occ %0d expected C/0C3/1", out_data0, out_ctrl0, occ0);
    end
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0 || occ0 !== 2'd0) begin
      n_bad++; $display("FAIL bp_drain: valid %b occ %0d expected 0/0", out_valid0, occ0);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 10'h0E1; in_data = DW'(32'hE);
    tick();
    in_ctrl = 10'h0F2; in_data = DW'(32'hF);
    tick();
    in_ctrl = 10'h155; in_data = DW'(32'hD); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== '0 || occ0 !== 2'd0 || in_ready0 !== 1'b1) begin
      n_bad++; $display("FAIL flush_full: valid %b ctrl %h occ %0d ready %b expected 0/0/0/1", out_valid0, out_ctrl0, occ0, in_ready0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (out_valid0 !== 1'b0) begin
        n_bad++; $display("FAIL flush_no_d_%0d: valid %b data %h expected no entry", k, out_valid0, out_data0);
      end
    end
    in_valid = 1'b1; in_ctrl = 10'h077; in_data = DW'(32'h6);
    tick();
    in_ctrl = 10'h188; in_data = DW'(32'h7); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid0 !== 1'b0 || occ0 !== 2'd0 || out_ctrl0 !== '0) begin
      n_bad++; $display("FAIL flush_one: valid %b occ %0d ctrl %h expected 0/0/0", out_valid0, occ0, out_ctrl0);
    end
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0) begin
      n_bad++; $display("FAIL flush_one_late: valid %b expected 0", out_valid0);
    end
  endtask

  task automatic test_bubble();
    logic [DW-1:0] x;
    x = rand_data() | DW'(1);
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 10'h3FF; in_data = x;
    tick();
    in_valid = 1'b0; in_ctrl = 10'h2AA; in_data = rand_data();
    n_cmp++;
    if (out_valid0 !== 1'b1 || out_ctrl0 !== 10'h3FF || out_data0 !== x) begin
      n_bad++; $display("FAIL bubble_load: valid %b ctrl %h expected 1/3FF", out_valid0, out_ctrl0);
    end
    tick();
    n_cmp++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== '0 || out_ctrl1 !== '0 || out_data0 !== x || out_data1 !== '0) begin
      n_bad++; $display("FAIL bubble_mask: ctrl %h/%h data0 %h data1 %h expected 0/0 held 0", out_ctrl0, out_ctrl1, out_data0, out_data1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      in_ctrl   = CW'($urandom());
      in_data   = rand_data();
      tick();
      n_cmp++;
      if (occ0 > 2'd2) begin
        n_bad++; $display("FAIL rand_occ_bound: occ %0d at step %0d", occ0, n);
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (occ0 !== 2'd0 || sb.size() != 0) begin
      n_bad++; $display("FAIL rand_drain: occ %0d model entries %0d expected 0", occ0, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_ctrl = 10'h111; in_data = DW'(32'h51);
    tick();
    in_ctrl = 10'h222; in_data = DW'(32'h52);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (occ0 !== 2'd2) begin
      n_bad++; $display("FAIL rstmid_full: occ %0d expected 2", occ0);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid0 !== 1'b0 || out_ctrl0 !== '0 || in_ready0 !== 1'b1 || occ0 !== 2'd0 || out_data0 !== '0) begin
      n_bad++; $display("FAIL rstmid_async: valid %b ctrl %h ready %b occ %0d data %h expected 0/0/1/0/0", out_valid0, out_ctrl0, in_ready0, occ0, out_data0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_bubble();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
